screen_sequencer: RTL and testbench
===================================

Name: screen_sequencer

Overview:
Screen-level game sequencer that sits directly upstream of vga_ctrl and drives its pix_data input. It runs the START -> PLAY -> END page flow and selects the pixel source for each page: page_start, the vga_draw game render, or page_end. All page switches are committed only at a frame boundary, so the screen never tears. It also gates game_logic through game_run and game_rst, and freezes the final score for page_end and the seven-segment display.

Parameters:
SCORE_W, 8, width of the score input and the latched score.
END_FRAMES, 120, minimum number of frames END is shown before a key can return to START (about 2 s at 60 Hz).
FCNT_W, 8, width of the frame counter; must satisfy 2^FCNT_W > END_FRAMES.

Ports:
vga_clk  in  1  pixel clock, the single clock of the block.
reset  in  1  synchronous, active-high reset.
pix_x  in  10  current scan X from vga_ctrl.
pix_y  in  10  current scan Y from vga_ctrl.
key_any  in  1  OR of the synchronised direction keys, level.
game_over  in  1  from game_logic, level or pulse.
score_in  in  SCORE_W  live tail count from game_logic.
start_pix  in  16  RGB565 pixel from page_start.
game_pix  in  16  RGB565 pixel from vga_draw.
end_pix  in  16  RGB565 pixel from page_end.
pix_data  out  16  selected RGB565 pixel to vga_ctrl.
game_run  out  1  game_logic update enable.
game_rst  out  1  one-cycle game_logic restart pulse.
score_hold  out  SCORE_W  score frozen on entry to END.
page  out  2  current page code.

Behaviour:
- Reset:
  - page=START (2'd0); pix_data=0; game_run=0; game_rst=0; score_hold=0.
  - Frame counter and all pending flags cleared.
  - Reset asserted mid-frame or mid-game forces the reset values on the next edge. No page switch is held over across reset.
- frame_tick:
  - One-cycle internal strobe, asserted on the cycle where {pix_x,pix_y} becomes {0,0} and was not {0,0} on the previous cycle.
  - Uses a registered previous-coordinate flag.
- key_rise: key_any AND NOT key_any_d (one registered stage).
- Pending flags:
  - key_pend is set by key_rise and cleared on frame_tick.
  - over_pend is set by game_over (level high on any cycle) and cleared on frame_tick.
  - Set wins over clear in the same cycle: the flag stays set and is consumed at the following tick.
- Page codes: START=0, PLAY=1, END=2. Code 3 is unused; if ever entered, the block returns to START on the next cycle.
- Transitions are evaluated only on frame_tick:
  - START -> PLAY if key_pend. game_rst=1 for exactly that cycle.
  - PLAY -> END if over_pend. score_hold <= score_in on that cycle; frame counter cleared.
  - END -> START if key_pend AND fcnt >= END_FRAMES. A key_pend while fcnt < END_FRAMES is discarded at that tick.
  - Key and over both pending in PLAY: END wins.
- Frame counter:
  - In END, increments on each frame_tick.
  - Saturates at 2^FCNT_W-1; no wrap.
- game_run: 1 iff page==PLAY. It is registered, so it changes one cycle after the transition tick.
- pix_data:
  - Registered mux: START->start_pix, PLAY->game_pix, END->end_pix.
  - Latency is 1 vga_clk from the pixel inputs to pix_data.
  - The upstream sources must be 1-cycle-aligned with it.
- score_hold changes only on PLAY->END and on reset.

Optional Feature:
Macro: SCREEN_PAUSE_EN.
- Defined:
  - Adds input pause_key (1 bit) and page code PAUSE=3.
  - A rising edge of pause_key in PLAY sets pause_pend. At the next tick the page goes PLAY -> PAUSE.
  - In PAUSE, a pause_key edge returns to PLAY at the next tick.
  - In PAUSE: game_run=0, and pix_data = game_pix with each of the R/G/B fields shifted right by 1 (dimmed).
  - In PLAY, over_pend has priority over pause_pend.
- Undefined:
  - No pause_key port; code 3 is illegal and recovers to START.
  - Behaviour is exactly as above.

Decomposition:
- Shared package/header (libs/define.vh):
  - page codes PG_START/PG_PLAY/PG_END/PG_PAUSE;
  - RGB565 field ranges R[15:11], G[10:5], B[4:0];
  - H_VALID=640 and V_VALID=480.
- One natural sub-module: frame_tick_gen (coordinate edge detector producing frame_tick), reused by game_upd_clk.

Test Plan:
1. Reset held 3 cycles, then released -> page=0, pix_data=0, game_run=0, score_hold=0.
2. In START, key_any pulse mid-frame -> page=1 at the next {0,0} cycle. game_rst high exactly 1 cycle; game_run=1 one cycle later; pix_data=game_pix (e.g. 16'hF800) after 1 cycle.
3. In PLAY with score_in=8'd23, game_over pulse for 1 cycle -> page=2 at the next tick; score_hold=23 and stays 23 while score_in changes to 24.
4. In END, key at frame 10 -> no change. Key at frame 121 -> page=0 at the following tick.
5. In PLAY, game_over and key_any in the same frame -> page=2 with no START pass; fcnt=0.
6. SCREEN_PAUSE_EN: pause_key edge in PLAY with game_pix=16'hFFFF -> page=3, game_run=0, pix_data=16'h7BEF. A second edge -> page=1.

Source files
------------

// File: rtl/screen_sequencer_pkg.sv
// Shared definitions for the screen sequencer: page codes, RGB565 field ranges
// and the active-area size. Also holds the dimming helper used in the pause page.
package screen_sequencer_pkg;

    typedef enum logic [1:0] {
        PG_START = 2'd0,
        PG_PLAY  = 2'd1,
        PG_END   = 2'd2,
        PG_PAUSE = 2'd3
    } page_t;

    localparam int R_HI = 15;
    localparam int R_LO = 11;
    localparam int G_HI = 10;
    localparam int G_LO = 5;
    localparam int B_HI = 4;
    localparam int B_LO = 0;

    localparam int H_VALID = 640;
    localparam int V_VALID = 480;

    // Halve each colour field independently so no bits bleed between fields.
    function automatic logic [15:0] rgb565_dim(input logic [15:0] p);
        return {1'b0, p[R_HI:R_LO+1], 1'b0, p[G_HI:G_LO+1], 1'b0, p[B_HI:B_LO+1]};
    endfunction

endpackage

// File: rtl/screen_sequencer_frame_tick_gen.sv
// Frame-start detector: one-cycle strobe when the scan coordinates arrive at {0,0}.
// Shared with the game update clock generator.
module frame_tick_gen (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    output logic       frame_tick
);

    logic at_origin;
    logic at_origin_d;

    assign at_origin = (pix_x == 10'd0) && (pix_y == 10'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            at_origin_d <= 1'b0;
        end else begin
            at_origin_d <= at_origin;
        end
    end

    assign frame_tick = at_origin && !at_origin_d;

endmodule

// File: rtl/screen_sequencer.sv
// START -> PLAY -> END page sequencer feeding vga_ctrl; page switches land on frame ticks.
// Optional pause page (code 3, dimmed game render) is enabled by defining SCREEN_PAUSE_EN.
module screen_sequencer
    import screen_sequencer_pkg::*;
#(
    parameter int SCORE_W    = 8,
    parameter int END_FRAMES = 120,
    parameter int FCNT_W     = 8
) (
    input  logic               vga_clk,
    input  logic               reset,
`ifdef SCREEN_PAUSE_EN
    input  logic               pause_key,
`endif
    input  logic [9:0]         pix_x,
    input  logic [9:0]         pix_y,
    input  logic               key_any,
    input  logic               game_over,
    input  logic [SCORE_W-1:0] score_in,
    input  logic [15:0]        start_pix,
    input  logic [15:0]        game_pix,
    input  logic [15:0]        end_pix,
    output logic [15:0]        pix_data,
    output logic               game_run,
    output logic               game_rst,
    output logic [SCORE_W-1:0] score_hold,
    output logic [1:0]         page
);

    localparam logic [FCNT_W-1:0] END_CNT = FCNT_W'(END_FRAMES);

    page_t             page_q;
    page_t             page_nxt;
    logic              frame_tick;
    logic              key_any_d;
    logic              key_pend;
    logic              over_pend;
    logic              enter_end;
    logic [FCNT_W-1:0] fcnt;
    logic [15:0]       pix_sel;

    frame_tick_gen u_frame_tick_gen (
        .clk        (vga_clk),
        .reset      (reset),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .frame_tick (frame_tick)
    );

`ifdef SCREEN_PAUSE_EN
    logic pause_key_d;
    logic pause_pend;

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            pause_key_d <= 1'b0;
            pause_pend  <= 1'b0;
        end else begin
            pause_key_d <= pause_key;
            pause_pend  <= (pause_key & ~pause_key_d) | (pause_pend & ~frame_tick);
        end
    end
`endif

    always_comb begin
        page_nxt  = page_q;
        game_rst  = 1'b0;
        enter_end = 1'b0;
        case (page_q)
            PG_START: begin
                if (frame_tick && key_pend) begin
                    page_nxt = PG_PLAY;
                    game_rst = !reset;
                end
            end
            PG_PLAY: begin
                // Game over outranks both a pending key and a pending pause.
                if (frame_tick && over_pend) begin
                    page_nxt  = PG_END;
                    enter_end = 1'b1;
`ifdef SCREEN_PAUSE_EN
                end else if (frame_tick && pause_pend) begin
                    page_nxt = PG_PAUSE;
`endif
                end
            end
            PG_END: begin
                if (frame_tick && key_pend && (fcnt >= END_CNT)) begin
                    page_nxt = PG_START;
                end
            end
`ifdef SCREEN_PAUSE_EN
            PG_PAUSE: begin
                if (frame_tick && pause_pend) begin
                    page_nxt = PG_PLAY;
                end
            end
`endif
            default: page_nxt = PG_START;
        endcase
    end

    always_comb begin
        pix_sel = 16'h0000;
        case (page_q)
            PG_START: pix_sel = start_pix;
            PG_PLAY:  pix_sel = game_pix;
            PG_END:   pix_sel = end_pix;
`ifdef SCREEN_PAUSE_EN
            PG_PAUSE: pix_sel = rgb565_dim(game_pix);
`endif
            default:  pix_sel = 16'h0000;
        endcase
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            page_q     <= PG_START;
            key_any_d  <= 1'b0;
            key_pend   <= 1'b0;
            over_pend  <= 1'b0;
            fcnt       <= '0;
            score_hold <= '0;
            game_run   <= 1'b0;
            pix_data   <= 16'h0000;
        end else begin
            page_q    <= page_nxt;
            key_any_d <= key_any;
            // A set arriving on the tick cycle survives to the following tick.
            key_pend  <= (key_any & ~key_any_d) | (key_pend & ~frame_tick);
            over_pend <= game_over | (over_pend & ~frame_tick);
            if (enter_end) begin
                score_hold <= score_in;
                fcnt       <= '0;
            end else if ((page_q == PG_END) && frame_tick && (fcnt != {FCNT_W{1'b1}})) begin
                fcnt <= fcnt + 1'b1;
            end
            game_run <= (page_nxt == PG_PLAY);
            pix_data <= pix_sel;
        end
    end

    assign page = page_q;

endmodule

// File: tb/tb_screen_sequencer.sv
// Testbench for screen_sequencer on a shrunken 8x4 scan, scoreboarded against a cycle model.
// Covers the pause page too when SCREEN_PAUSE_EN is defined.
`timescale 1ns/1ps
module tb_screen_sequencer;
    import screen_sequencer_pkg::*;

    localparam int SCORE_W    = 8;
    localparam int END_FRAMES = 120;
    localparam int FCNT_W     = 8;
    localparam int SCAN_W     = 8;
    localparam int SCAN_H     = 4;

    logic               vga_clk   = 1'b0;
    logic               reset     = 1'b1;
    logic [9:0]         pix_x     = '0;
    logic [9:0]         pix_y     = '0;
    logic               key_any   = 1'b0;
    logic               game_over = 1'b0;
    logic [SCORE_W-1:0] score_in  = '0;
    logic [15:0]        start_pix = 16'h1111;
    logic [15:0]        game_pix  = 16'h2222;
    logic [15:0]        end_pix   = 16'h3333;
`ifdef SCREEN_PAUSE_EN
    logic               pause_key = 1'b0;
`endif
    logic [15:0]        pix_data;
    logic               game_run;
    logic               game_rst;
    logic [SCORE_W-1:0] score_hold;
    logic [1:0]         page;

    always #5 vga_clk = ~vga_clk;

    screen_sequencer #(
        .SCORE_W    (SCORE_W),
        .END_FRAMES (END_FRAMES),
        .FCNT_W     (FCNT_W)
    ) dut (
        .vga_clk    (vga_clk),
        .reset      (reset),
`ifdef SCREEN_PAUSE_EN
        .pause_key  (pause_key),
`endif
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .key_any    (key_any),
        .game_over  (game_over),
        .score_in   (score_in),
        .start_pix  (start_pix),
        .game_pix   (game_pix),
        .end_pix    (end_pix),
        .pix_data   (pix_data),
        .game_run   (game_run),
        .game_rst   (game_rst),
        .score_hold (score_hold),
        .page       (page)
    );

    typedef struct packed {
        logic [15:0]        pix;
        logic [1:0]         pg;
        logic               run;
        logic [SCORE_W-1:0] score;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   passed = 0;
    int   rst_hi = 0;
    logic started = 1'b0;

    // Reference model state
    logic [1:0]         m_page = 2'd0;
    logic               m_kp = 1'b0, m_op = 1'b0, m_pp = 1'b0;
    logic               m_zero_d = 1'b0, m_key_d = 1'b0, m_pause_d = 1'b0;
    int                 m_fcnt = 0;
    logic [SCORE_W-1:0] m_score = '0;
    logic               m_rst_raw = 1'b0;
    logic               m_tick_taken = 1'b0;

    task automatic step();
        logic       tick, krise, prise, pkey;
        logic [1:0] np;
        logic [15:0] sel;
        exp_t       e;
`ifdef SCREEN_PAUSE_EN
        pkey = pause_key;
`else
        pkey = 1'b0;
`endif
        tick  = (pix_x == 10'd0) && (pix_y == 10'd0) && !m_zero_d;
        krise = key_any && !m_key_d;
        prise = pkey && !m_pause_d;
        if (reset) begin
            m_page = 2'd0; m_kp = 1'b0; m_op = 1'b0; m_pp = 1'b0;
            m_zero_d = 1'b0; m_key_d = 1'b0; m_pause_d = 1'b0;
            m_fcnt = 0; m_score = '0;
            e = '{pix: 16'h0000, pg: 2'd0, run: 1'b0, score: '0};
            m_tick_taken = 1'b0;
        end else begin
            case (m_page)
                2'd0:    sel = start_pix;
                2'd1:    sel = game_pix;
                2'd2:    sel = end_pix;
`ifdef SCREEN_PAUSE_EN
                default: sel = {1'b0, game_pix[15:12], 1'b0, game_pix[10:6], 1'b0, game_pix[4:1]};
`else
                default: sel = 16'h0000;
`endif
            endcase
            np = m_page;
            if (tick) begin
                case (m_page)
                    2'd0: if (m_kp) np = 2'd1;
                    2'd1: begin
                        if (m_op) begin
                            np = 2'd2; m_score = score_in; m_fcnt = -1;
`ifdef SCREEN_PAUSE_EN
                        end else if (m_pp) begin
                            np = 2'd3;
`endif
                        end
                    end
                    2'd2: if (m_kp && m_fcnt >= END_FRAMES) np = 2'd0;
                    default: begin
`ifdef SCREEN_PAUSE_EN
                        if (m_pp) np = 2'd1;
`else
                        np = 2'd0;
`endif
                    end
                endcase
                if (m_page == 2'd2 && m_fcnt < 255) m_fcnt++;
                if (m_fcnt < 0) m_fcnt = 0;
            end else begin
`ifndef SCREEN_PAUSE_EN
                if (m_page == 2'd3) np = 2'd0;
`endif
            end
            m_kp = krise | (m_kp & ~tick);
            m_op = game_over | (m_op & ~tick);
            m_pp = prise | (m_pp & ~tick);
            m_zero_d  = (pix_x == 10'd0) && (pix_y == 10'd0);
            m_key_d   = key_any;
            m_pause_d = pkey;
            m_page = np;
            m_tick_taken = tick;
            e = '{pix: sel, pg: np, run: (np == 2'd1), score: m_score};
        end
        @(posedge vga_clk);
        #1;
        sb_q.push_back(e);
        started = 1'b1;
        if (pix_x == SCAN_W - 1) begin
            pix_x = '0;
            pix_y = (pix_y == SCAN_H - 1) ? 10'd0 : pix_y + 10'd1;
        end else begin
            pix_x = pix_x + 10'd1;
        end
        start_pix = 16'($urandom);
        game_pix  = 16'($urandom);
        end_pix   = 16'($urandom);
        m_rst_raw = (pix_x == 10'd0) && (pix_y == 10'd0) && !m_zero_d && (m_page == 2'd0) && m_kp;
    endtask

    task automatic go_tick();
        int n = 0;
        do begin
            step();
            n++;
        end while (!m_tick_taken && n < 2 * SCAN_W * SCAN_H);
        if (!m_tick_taken) begin
            checks++;
            $display("FAIL go_tick: no frame tick within %0d cycles", n);
        end
    endtask

    task automatic press_key();
        key_any = 1'b1;
        step();
        step();
        key_any = 1'b0;
        step();
    endtask

    // Scoreboard: registered outputs against the model, plus the combinational game_rst
    always @(negedge vga_clk) begin
        exp_t e;
        if (game_rst === 1'b1) rst_hi++;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (pix_data !== e.pix) $display("FAIL sb_pix_data: got %h expected %h at %0t", pix_data, e.pix, $time);
            else passed++;
            checks++;
            if (page !== e.pg) $display("FAIL sb_page: got %0d expected %0d at %0t", page, e.pg, $time);
            else passed++;
            checks++;
            if (game_run !== e.run) $display("FAIL sb_game_run: got %b expected %b at %0t", game_run, e.run, $time);
            else passed++;
            checks++;
            if (score_hold !== e.score) $display("FAIL sb_score_hold: got %0d expected %0d at %0t", score_hold, e.score, $time);
            else passed++;
        end
        if (started) begin
            checks++;
            if (game_rst !== (m_rst_raw && !reset))
                $display("FAIL sb_game_rst: got %b expected %b at %0t", game_rst, m_rst_raw && !reset, $time);
            else passed++;
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        checks++; if (page !== 2'd0) $display("FAIL reset_page: got %0d expected 0", page); else passed++;
        checks++; if (pix_data !== 16'h0000) $display("FAIL reset_pix: got %h expected 0000", pix_data); else passed++;
        checks++; if (game_run !== 1'b0) $display("FAIL reset_run: got %b expected 0", game_run); else passed++;
        checks++; if (score_hold !== '0) $display("FAIL reset_score: got %0d expected 0", score_hold); else passed++;
        checks++; if (game_rst !== 1'b0) $display("FAIL reset_game_rst: got %b expected 0", game_rst); else passed++;
        reset = 1'b0;
        step();
    endtask

    task automatic test_start_to_play();
        int r0;
        go_tick();
        repeat (5) step();
        press_key();
        checks++; if (page !== 2'd0) $display("FAIL start_hold: got page %0d expected 0", page); else passed++;
        r0 = rst_hi;
        go_tick();
        checks++; if (page !== 2'd1) $display("FAIL start_play_page: got %0d expected 1", page); else passed++;
        checks++; if (game_run !== 1'b1) $display("FAIL start_play_run: got %b expected 1", game_run); else passed++;
        checks++; if (rst_hi - r0 !== 1) $display("FAIL game_rst_width: got %0d cycles expected 1", rst_hi - r0); else passed++;
        game_pix = 16'hF800;
        step();
        checks++; if (pix_data !== 16'hF800) $display("FAIL play_pix: got %h expected F800", pix_data); else passed++;
    endtask

    task automatic test_play_to_end();
        score_in = 8'd23;
        repeat (3) step();
        game_over = 1'b1;
        step();
        game_over = 1'b0;
        step();
        checks++; if (page !== 2'd1) $display("FAIL over_wait: got page %0d expected 1", page); else passed++;
        go_tick();
        checks++; if (page !== 2'd2) $display("FAIL end_page: got %0d expected 2", page); else passed++;
        checks++; if (score_hold !== 8'd23) $display("FAIL score_latch: got %0d expected 23", score_hold); else passed++;
        checks++; if (game_run !== 1'b0) $display("FAIL end_run: got %b expected 0", game_run); else passed++;
        score_in = 8'd24;
        repeat (10) step();
        checks++; if (score_hold !== 8'd23) $display("FAIL score_frozen: got %0d expected 23", score_hold); else passed++;
    endtask

    task automatic test_end_return();
        for (int i = 0; i < 300 && m_fcnt < 9; i++) go_tick();
        press_key();
        go_tick();
        checks++; if (page !== 2'd2) $display("FAIL early_key: got page %0d expected 2", page); else passed++;
        for (int i = 0; i < 300 && m_fcnt < END_FRAMES - 1; i++) go_tick();
        press_key();
        go_tick();
        checks++; if (page !== 2'd2) $display("FAIL key_fcnt_119: got page %0d expected 2", page); else passed++;
        press_key();
        go_tick();
        checks++; if (page !== 2'd0) $display("FAIL key_fcnt_120: got page %0d expected 0", page); else passed++;
    endtask

    task automatic test_over_and_key();
        press_key();
        go_tick();
        checks++; if (page !== 2'd1) $display("FAIL replay_page: got %0d expected 1", page); else passed++;
        score_in = 8'd77;
        repeat (3) step();
        game_over = 1'b1;
        key_any   = 1'b1;
        step();
        game_over = 1'b0;
        step();
        key_any = 1'b0;
        go_tick();
        checks++; if (page !== 2'd2) $display("FAIL over_beats_key: got page %0d expected 2", page); else passed++;
        checks++; if (score_hold !== 8'd77) $display("FAIL score_latch2: got %0d expected 77", score_hold); else passed++;
        go_tick();
        checks++; if (page !== 2'd2) $display("FAIL no_start_pass: got page %0d expected 2", page); else passed++;
    endtask

    task automatic test_reset_midgame();
        press_key();
        reset = 1'b1;
        step();
        checks++; if (page !== 2'd0) $display("FAIL mid_reset_page: got %0d expected 0", page); else passed++;
        checks++; if (score_hold !== '0) $display("FAIL mid_reset_score: got %0d expected 0", score_hold); else passed++;
        checks++; if (pix_data !== 16'h0000) $display("FAIL mid_reset_pix: got %h expected 0000", pix_data); else passed++;
        reset = 1'b0;
        go_tick();
        checks++; if (page !== 2'd0) $display("FAIL reset_drops_pend: got page %0d expected 0", page); else passed++;
    endtask

`ifdef SCREEN_PAUSE_EN
    task automatic test_pause();
        press_key();
        go_tick();
        repeat (3) step();
        pause_key = 1'b1;
        step();
        step();
        pause_key = 1'b0;
        go_tick();
        checks++; if (page !== 2'd3) $display("FAIL pause_page: got %0d expected 3", page); else passed++;
        checks++; if (game_run !== 1'b0) $display("FAIL pause_run: got %b expected 0", game_run); else passed++;
        game_pix = 16'hFFFF;
        step();
        checks++; if (pix_data !== 16'h7BEF) $display("FAIL pause_dim: got %h expected 7BEF", pix_data); else passed++;
        repeat (3) step();
        pause_key = 1'b1;
        step();
        pause_key = 1'b0;
        go_tick();
        checks++; if (page !== 2'd1) $display("FAIL unpause_page: got %0d expected 1", page); else passed++;
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_start_to_play();
        test_play_to_end();
        test_end_return();
        test_over_and_key();
        test_reset_midgame();
`ifdef SCREEN_PAUSE_EN
        test_pause();
`endif
        step();
        @(negedge vga_clk);
        #1;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
